// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter: FSM states,
// requester port indices and default geometry.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int PORT_PPU    = 0;
  localparam int PORT_CPU    = 1;
  localparam int PORT_LOADER = 2;

  localparam int NPORT_DEF   = 3;
  localparam int AW_DEF      = 22;
  localparam int DW_DEF      = 16;
  localparam int AGE_MAX_DEF = 63;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: aged requesters beat non-aged ones, and the
// lowest index wins within whichever group is chosen.
module sdram_arb_pick #(
  parameter int NPORT = 3,
  parameter int IW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] aged,
  output logic [IW-1:0]    win,
  output logic             valid
);

  logic [NPORT-1:0] aged_req_s;
  logic [NPORT-1:0] cand_s;

  // Narrow the candidate set to aged requesters when any exist
  always_comb begin
    aged_req_s = req & aged;
    if (|aged_req_s) begin
      cand_s = aged_req_s;
    end else begin
      cand_s = req;
    end
  end

  // Scan from the top so the lowest-index candidate is written last
  always_comb begin
    win   = {IW{1'b0}};
    valid = 1'b0;
    for (int p = NPORT - 1; p >= 0; p--) begin
      win   = cand_s[p] ? IW'(p) : win;
      valid = valid | cand_s[p];
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller req/ack port among NPORT requesters, one access
// in flight at a time. Define SDRAM_ARB_AGING_EN to add per-port aging.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORT   = NPORT_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int AGE_MAX = AGE_MAX_DEF,
  localparam int IW     = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [NPORT-1:0]   req_i,
  input  logic [NPORT-1:0]   we_i,
  input  logic [NPORT*AW-1:0] addr_i,
  input  logic [NPORT*DW-1:0] wdata_i,
  input  logic [NPORT*2-1:0] ds_i,
  output logic [NPORT-1:0]   ack_o,
  output logic [DW-1:0]      rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  output logic [1:0]         mem_ds_o,
  input  logic               mem_ack_i,
  input  logic [DW-1:0]      mem_rdata_i,
  output logic               busy_o,
  output logic [IW-1:0]      gnt_id_o
);

  arb_state_t       state_r, next_state_s;
  logic [NPORT-1:0] aged_s;
  logic [IW-1:0]    win_s;
  logic             win_valid_s;
  logic [IW-1:0]    gnt_r;
  logic [NPORT-1:0] ack_r;
  logic [DW-1:0]    rdata_r;
  logic             mem_req_r, mem_we_r, busy_r;
  logic [AW-1:0]    mem_addr_r;
  logic [DW-1:0]    mem_wdata_r;
  logic [1:0]       mem_ds_r;

  sdram_arb_pick #(.NPORT(NPORT), .IW(IW)) u_pick (
    .req   (req_i),
    .aged  (aged_s),
    .win   (win_s),
    .valid (win_valid_s)
  );

`ifdef SDRAM_ARB_AGING_EN
  localparam int CW = $clog2(AGE_MAX + 1);
  logic [CW-1:0]    age_r [NPORT];
  logic [NPORT-1:0] served_s;

  // A port counts as aged once its wait counter saturates
  always_comb begin
    aged_s = {NPORT{1'b0}};
    for (int p = 0; p < NPORT; p++) begin
      aged_s[p] = (age_r[p] == CW'(AGE_MAX));
    end
  end

  // A port is served from its grant until the arbiter returns to IDLE
  always_comb begin
    served_s = {NPORT{1'b0}};
    for (int p = 0; p < NPORT; p++) begin
      served_s[p] = ((state_r == IDLE) && win_valid_s && (win_s == IW'(p))) ||
                    ((state_r != IDLE) && (gnt_r == IW'(p)));
    end
  end

  // Saturating wait counters, cleared on service or when the request drops
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPORT; p++) age_r[p] <= {CW{1'b0}};
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (!req_i[p] || served_s[p]) begin
          age_r[p] <= {CW{1'b0}};
        end else if (age_r[p] != CW'(AGE_MAX)) begin
          age_r[p] <= age_r[p] + CW'(1);
        end
      end
    end
  end
`else
  logic unused_age_s;
  assign aged_s       = {NPORT{1'b0}};
  assign unused_age_s = (AGE_MAX != 0);
`endif

  // Next-state logic; arbitration only happens from IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) next_state_s = BUSY;
        else             next_state_s = IDLE;
      end
      BUSY: begin
        if (mem_ack_i) next_state_s = DONE;
        else           next_state_s = BUSY;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Registered grant, controller fields, ack pulse and read data
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      gnt_r       <= {IW{1'b0}};
      ack_r       <= {NPORT{1'b0}};
      rdata_r     <= {DW{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      mem_ds_r    <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            gnt_r       <= win_s;
            mem_req_r   <= 1'b1;
            mem_we_r    <= we_i[win_s];
            mem_addr_r  <= addr_i[int'(win_s)*AW +: AW];
            mem_wdata_r <= wdata_i[int'(win_s)*DW +: DW];
            mem_ds_r    <= ds_i[int'(win_s)*2 +: 2];
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_r <= 1'b0;
            rdata_r   <= mem_rdata_i;
            ack_r     <= {{(NPORT-1){1'b0}}, 1'b1} << gnt_r;
          end
        end
        DONE:    ack_r <= {NPORT{1'b0}};
        default: ack_r <= {NPORT{1'b0}};
      endcase
    end
  end

  assign ack_o       = ack_r;
  assign rdata_o     = rdata_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_ds_o    = mem_ds_r;
  assign busy_o      = busy_r;
  assign gnt_id_o    = gnt_r;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single-port SDRAM controller among the NES core's memory requesters: PPU, CPU and ROM loader. Fixed-priority selection with an optional aging guard; one access in flight at a time. Sits between the requesters and the SDRAM controller's req/ack port. The debug outputs are exposed for on-chip logic-analyzer probing alongside the SDRAM pins.

## Interface
- NPORT, 3, number of requesters; port 0 has highest priority
- AW, 22, word address width
- DW, 16, data width
- AGE_MAX, 63, aging threshold in cycles; used only with the aging macro
- sys_clk  in  1  system clock; all logic is on its rising edge
- rst  in  1  reset, asynchronous, active-high
- req_i  in  NPORT  per-port request level
- we_i  in  NPORT  per-port write enable; 1 = write
- addr_i  in  NPORT*AW  per-port address; port p uses slice [p*AW +: AW]
- wdata_i  in  NPORT*DW  per-port write data
- ds_i  in  NPORT*2  per-port byte strobes
- ack_o  out  NPORT  one-cycle completion pulse per port
- rdata_o  out  DW  read data; valid while the matching ack_o is high
- mem_req_o, mem_we_o  out  1  request and write enable to the controller
- mem_addr_o  out  AW  address to the controller
- mem_wdata_o  out  DW  write data to the controller
- mem_ds_o  out  2  byte strobes to the controller
- mem_ack_i  in  1  controller completion
- mem_rdata_i  in  DW  controller read data
- busy_o  out  1  high when the FSM is not in IDLE
- gnt_id_o  out  $clog2(NPORT)  index of the last granted port

## Operation
- Requester rule: hold req_i high with stable we_i, addr_i, wdata_i and ds_i until ack_o[p] is sampled high. Drop req_i on the following cycle or later.
- FSM states and transitions:
  - IDLE: if any req_i is high, pick a winner g. Register g's fields onto the mem_* outputs, set mem_req_o=1, set gnt_id_o=g, go to BUSY. If no req_i is high, stay in IDLE.
  - BUSY: hold mem_req_o and all mem_* fields stable. When mem_ack_i=1, clear mem_req_o, capture rdata_o<=mem_rdata_i, set ack_o[g]=1, go to DONE.
  - DONE: clear ack_o, go to IDLE. No arbitration happens in DONE.
- Winner selection: lowest-index requesting port.
- mem_ack_i is ignored outside BUSY.
- rdata_o holds its value until the next capture. On writes, rdata_o is undefined but still registered.
- Reset value of every output is 0: ack_o, rdata_o, mem_*, busy_o, gnt_id_o. State resets to IDLE.
- Reset mid-access abandons the in-flight transfer. The SDRAM controller shares rst and must abort with it. No ack_o is issued for the abandoned access.

## Timing
- Request first seen high at edge 0 → mem_req_o high from edge 1.
- mem_ack_i sampled at edge k → ack_o high for cycle k+1 only.
- Minimum req-to-ack latency: 3 cycles. Minimum back-to-back grant spacing: 3 cycles, i.e. IDLE→BUSY→DONE with a 1-cycle BUSY.
- Simultaneous requests in IDLE: exactly one winner. Losers keep waiting, with no ack and no state loss.
- A req_i deasserted before its ack is a protocol violation. An already-issued access still completes and pulses ack_o.

## Configuration
- SDRAM_ARB_AGING_EN defined:
  - Each port has a saturating wait counter, width $clog2(AGE_MAX+1).
  - The counter increments each cycle the port's req_i is high and the port is not granted.
  - The counter clears on grant or when req_i is low.
  - Ports whose counter equals AGE_MAX win over non-aged ports; the lowest index wins among aged ports.
  - Counters reset to 0.
- SDRAM_ARB_AGING_EN undefined: strict fixed priority, and no counters are generated.

## Structure
- Package sdram_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - port index constants PORT_PPU=0, PORT_CPU=1, PORT_LOADER=2
  - default NPORT, AW, DW
- One combinational sub-module, sdram_arb_pick. It takes req and aged vectors and returns the winner index plus a valid flag. It is reused by the aging and non-aging builds.

## Test plan
- Single read: port 1 requests addr 0x01234; mem_ack_i arrives 4 cycles after mem_req_o rises with rdata 0xBEEF. Expect ack_o=3'b010 for exactly 1 cycle, rdata_o=0xBEEF, gnt_id_o=1.
- Priority: ports 0 and 2 request in the same cycle. Expect port 0 granted first. Port 2 is granted in the IDLE cycle after port 0's DONE; mem_addr_o switches only at that grant.
- Write path: port 2 writes 0x5A5A with ds=2'b01. Expect mem_we_o=1, mem_wdata_o=0x5A5A, mem_ds_o=2'b01, all stable through BUSY until mem_ack_i.
- Aging (macro on, AGE_MAX=8): port 0 requests continuously and port 2 is held pending. Expect port 2 granted once its counter reaches 8, ahead of pending port 0. With the macro off, port 2 never wins.
- Reset mid-BUSY: assert rst 2 cycles after mem_req_o rises. Expect all outputs 0 immediately (asynchronous) and no ack_o after release. The next request completes normally.
- Back-to-back: port 1 re-requests on the cycle after its ack. Expect a second grant with 3-cycle minimum spacing and no duplicate ack.
